plot_clip_fifo: RTL and testbench

PLOT_CLIP_FIFO -- requirements
Module: plot_clip_fifo

---
 rtl/plot_clip_fifo_pkg.sv | 28 ++
 rtl/plot_clip_fifo_fifo.sv | 72 +++++++
 rtl/plot_clip_fifo.sv | 155 +++++++++++++++
 tb/tb_plot_clip_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_clip_fifo_pkg.sv
// Shared definitions for the pixel clipping FIFO: screen geometry,
// the stored pixel record, the completion FSM states and a counter helper.
package plot_clip_fifo_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // One framebuffer write: coordinates already reduced to framebuffer width.
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    // Completion tracking: ACTIVE while pixels may arrive, DRAIN once the
    // engine reports it is finished, DONE when everything has been plotted.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        return (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/plot_clip_fifo_fifo.sv
// pixel_fifo: small circular buffer of pixel_t entries. The head entry is
// visible combinationally on rd_data; the consumer registers it when popping.
module pixel_fifo
    import plot_clip_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  pixel_t wr_data,
    input  logic   pop,
    output pixel_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    pixel_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/plot_clip_fifo.sv
// plot_clip_fifo: accepts signed pixel coordinates from a drawing engine,
// discards those outside the 160x120 framebuffer, buffers the rest and
// issues one-cycle VGA write strobes. Also counts plotted and clipped
// pixels and reports when the engine's work has fully reached the screen.
module plot_clip_fifo
    import plot_clip_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_done,
    input  logic        hold,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        done,
    output logic [15:0] plotted_cnt,
    output logic [15:0] clipped_cnt
);

    localparam logic signed [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic signed [7:0] Y_MAX = 8'(SCREEN_H - 1);

    logic   fifo_full;
    logic   fifo_empty;
    pixel_t head;
    pixel_t wr_pixel;
    logic   x_on;
    logic   y_on;
    logic   push_acc;
    logic   store;
    logic   pop;

    logic [7:0]  vga_x_q,      vga_x_d;
    logic [6:0]  vga_y_q,      vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        vga_plot_q,   vga_plot_d;
    logic [15:0] plotted_q,    plotted_d;
    logic [15:0] clipped_q,    clipped_d;
    state_t      state_q,      state_d;
    logic        done_q,       done_d;

    // in_ready looks only at the registered occupancy, never at a same-cycle pop.
    assign in_ready = !fifo_full;
    assign push_acc = in_valid && in_ready;

    // Signed window test: negative coordinates have the sign bit set and fail >= 0.
    assign x_on  = ($signed(in_x) >= 9'sd0) && ($signed(in_x) <= X_MAX);
    assign y_on  = ($signed(in_y) >= 8'sd0) && ($signed(in_y) <= Y_MAX);
    assign store = push_acc && x_on && y_on;
    assign pop   = !fifo_empty && !hold;

    assign wr_pixel = '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (store),
        .wr_data (wr_pixel),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output stage: a pop captures the head entry and strobes for one cycle.
    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        if (pop) begin
            vga_x_d      = head.x;
            vga_y_d      = head.y;
            vga_colour_d = head.colour;
            vga_plot_d   = 1'b1;
        end
        plotted_d = sat_inc16(plotted_q, pop);
        clipped_d = sat_inc16(clipped_q, push_acc && !store);
    end

    // Output and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            plotted_q    <= '0;
            clipped_q    <= '0;
        end else begin
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            plotted_q    <= plotted_d;
            clipped_q    <= clipped_d;
        end
    end

    // Completion FSM next state; done mirrors the DONE state after the edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE: begin
                if (in_done && !push_acc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_done) begin
                    state_d = ACTIVE;
                end else if (fifo_empty && !pop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!in_done || push_acc) begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = ACTIVE;
        endcase
        done_d = (state_d == DONE);
    end

    // Completion FSM state and its registered done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACTIVE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;
    assign done        = done_q;
    assign plotted_cnt = plotted_q;
    assign clipped_cnt = clipped_q;

endmodule

// File: tb/tb_plot_clip_fifo.sv
// Bench for plot_clip_fifo: directed pixel streams; expected strobes are
// queued when a pixel is accepted and a negedge monitor checks every strobe.
module tb_plot_clip_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_x;
    logic [7:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_done;
    logic        hold;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        done;
    logic [15:0] plotted_cnt;
    logic [15:0] clipped_cnt;

    typedef struct {
        int x;
        int y;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   strobe_cnt = 0;
    bit   quiet      = 1'b0;

    plot_clip_fifo #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_colour   (in_colour),
        .in_done     (in_done),
        .hold        (hold),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .done        (done),
        .plotted_cnt (plotted_cnt),
        .clipped_cnt (clipped_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (vga_plot === 1'b1) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got (%0d,%0d,%0d) required no strobe",
                         vga_x, vga_y, vga_colour);
            end else begin
                e = exp_q.pop_front();
                if (vga_x !== 8'(e.x) || vga_y !== 7'(e.y) || vga_colour !== 3'(e.c)) begin
                    errors++;
                    $display("FAIL strobe_data: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                end else if (!quiet) begin
                    $display("strobe (%0d,%0d,%0d) ok", vga_x, vga_y, vga_colour);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer one pixel and wait (bounded) for it to be accepted; leaves in_valid high.
    task automatic send(input int x, input int y, input int c);
        int w;
        in_valid  = 1'b1;
        in_x      = 9'(x);
        in_y      = 8'(y);
        in_colour = 3'(c);
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=%0b required 1 for (%0d,%0d)", in_ready, x, y);
            in_valid = 1'b0;
            return;
        end
        if (x >= 0 && x <= 159 && y >= 0 && y <= 119) begin
            exp_q.push_back('{x, y, c});
        end
        if (!quiet) $display("push (%0d,%0d,%0d)", x, y, c);
        @(posedge clk);
        step();
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int w;
        int idx;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
        in_done = 1'b0; hold = 1'b0;
        repeat (3) step();
        chk("reset_plot", vga_plot, 0);
        chk("reset_x", vga_x, 0);
        chk("reset_done", done, 0);
        chk("reset_plotted", plotted_cnt, 0);
        chk("reset_clipped", clipped_cnt, 0);
        chk("reset_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // Single on-screen pixel: strobe appears after the second edge.
        send(5, 7, 3);
        in_valid = 1'b0;
        chk("t1_no_plot_at_n", vga_plot, 0);
        step();
        chk("t1_plot_at_n1", vga_plot, 1);
        chk("t1_x", vga_x, 5);
        chk("t1_y", vga_y, 7);
        chk("t1_colour", vga_colour, 3);
        chk("t1_plotted", plotted_cnt, 1);
        step();
        chk("t1_plot_one_cycle", vga_plot, 0);
        chk("t1_x_held", vga_x, 5);

        // Off-screen pixels on each boundary are swallowed and counted.
        send(-1, 10, 1);  chk("t2_ready_a", in_ready, 1);
        send(160, 10, 2); chk("t2_ready_b", in_ready, 1);
        send(10, 120, 4); chk("t2_ready_c", in_ready, 1);
        send(10, -5, 5);  chk("t2_ready_d", in_ready, 1);
        in_valid = 1'b0;
        repeat (3) step();
        chk("t2_clipped", clipped_cnt, 4);
        chk("t2_plotted", plotted_cnt, 1);

        // Hold with six pixels: fills at four, then all drain back to back.
        hold = 1'b1;
        send(1, 1, 1);
        send(2, 2, 2);
        send(3, 3, 3);
        send(4, 4, 4);
        chk("t3_full_ready", in_ready, 0);
        in_x = 9'd5; in_y = 8'd5; in_colour = 3'd5;
        repeat (2) step();
        chk("t3_still_full", in_ready, 0);
        chk("t3_no_plot_held", vga_plot, 0);
        base = strobe_cnt;
        hold = 1'b0;
        send(5, 5, 5);
        send(6, 6, 6);
        in_valid = 1'b0;
        chk("t3_strobes_3", strobe_cnt - base, 3);
        repeat (3) step();
        chk("t3_strobes_6", strobe_cnt - base, 6);
        step();
        chk("t3_idle", vga_plot, 0);
        chk("t3_plotted", plotted_cnt, 7);

        // Completion: done only after the last buffered pixel is plotted.
        hold = 1'b1;
        send(10, 20, 1);
        send(11, 21, 2);
        send(12, 22, 3);
        in_valid = 1'b0;
        in_done = 1'b1;
        repeat (3) step();
        chk("t4_done_held", done, 0);
        hold = 1'b0;
        step();
        step();
        step();
        chk("t4_third_strobe", vga_plot, 1);
        chk("t4_done_at_third", done, 0);
        step();
        chk("t4_done_set", done, 1);
        chk("t4_plotted", plotted_cnt, 10);
        in_done = 1'b0;
        step();
        chk("t4_done_clear", done, 0);

        // Reset with pixels buffered: they vanish without strobes.
        hold = 1'b1;
        send(30, 31, 6);
        send(32, 33, 7);
        send(34, 35, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("t5_plot", vga_plot, 0);
        chk("t5_x", vga_x, 0);
        chk("t5_y", vga_y, 0);
        chk("t5_colour", vga_colour, 0);
        chk("t5_done", done, 0);
        chk("t5_plotted", plotted_cnt, 0);
        chk("t5_clipped", clipped_cnt, 0);
        chk("t5_ready", in_ready, 1);
        exp_q.delete();
        rst = 1'b0;
        hold = 1'b0;
        base = strobe_cnt;
        repeat (5) step();
        chk("t5_no_strobes", strobe_cnt - base, 0);

        // Full-screen raster in blocks of 64 with an idle cycle between blocks.
        quiet = 1'b1;
        for (int b = 0; b < 300; b++) begin
            for (int k = 0; k < 64; k++) begin
                idx = b * 64 + k;
                send(idx % 160, idx / 160, idx % 8);
            end
            in_valid = 1'b0;
            step();
        end
        $display("raster of 19200 pixels issued");
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            step();
            w++;
        end
        step();
        quiet = 1'b0;
        chk("t6_last_x", vga_x, 159);
        chk("t6_last_y", vga_y, 119);
        chk("t6_plotted", plotted_cnt, 19200);
        chk("t6_clipped", clipped_cnt, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
